// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_disp_pkg : segment codes and slot encoding for the BCD display scanner |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package bcd_disp_pkg;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    SLOT_THOU  = 2'd0,
    SLOT_HUND  = 2'd1,
    SLOT_TENTH = 2'd2,
    SLOT_ONES  = 2'd3
  } slot_t;

  function automatic logic [3:0] slot_onehot(input slot_t s);
    return 4'b0001 << s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_to_7seg : BCD digit to active-high seven-segment code, dash above 9    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_display_scanner : multiplexes a frame-snapshotted 4-digit BCD time     |
// | onto a seven-segment display with per-slot blanking. Rev 1.0               |
// +----------------------------------------------------------------------------+
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       hold,
  input  logic [3:0] ones,
  input  logic [3:0] tenths,
  input  logic [3:0] hundreths,
  input  logic [3:0] thousandths,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int            PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TC_VAL    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_VAL = PW'(BLANK_CYC);
  localparam logic          INV       = (COMMON_ANODE != 0);

  logic [PW-1:0] presc;
  slot_t         slot;
  logic [15:0]   snap;   // {ones, tenths, hundreths, thousandths}
  logic          tc;
  logic          wrap;
  logic          lit;
  logic [3:0]    digit;
  logic [6:0]    seg_hi;
  logic [3:0]    an_hi;

  assign tc    = (presc == TC_VAL);
  assign wrap  = enable && tc && (slot == SLOT_ONES);
  assign lit   = enable && (presc >= BLANK_VAL);
  assign an_hi = slot_onehot(slot);

  always_comb begin
    digit = snap[3:0];
    case (slot)
      SLOT_THOU:  digit = snap[3:0];
      SLOT_HUND:  digit = snap[7:4];
      SLOT_TENTH: digit = snap[11:8];
      SLOT_ONES:  digit = snap[15:12];
      default:    digit = snap[3:0];
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (seg_hi)
  );

  // Outputs are computed from the pre-edge state, so the display lags the counters by one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      slot       <= SLOT_THOU;
      snap       <= 16'h0000;
      frame_done <= 1'b0;
      seg        <= {7{INV}};
      dp         <= INV;
      an         <= {4{INV}};
    end else begin
      if (enable) begin
        if (tc) begin
          presc <= '0;
          slot  <= slot_t'(slot + 2'd1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (wrap && !hold) begin
        snap <= {ones, tenths, hundreths, thousandths};
      end
      frame_done <= wrap;
      an         <= {4{INV}} ^ (lit ? an_hi : 4'h0);
      seg        <= {7{INV}} ^ (lit ? seg_hi : 7'h00);
      dp         <= INV ^ (lit && (slot == SLOT_ONES));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// Scoreboard bench: expected display events are queued by the stimulus and
// consumed by per-DUT monitors whenever a digit is lit or frame_done pulses.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] ones = 4'd0, tenths = 4'd0, hundreths = 4'd0, thousandths = 4'd0;

  logic [6:0] seg_ca, seg_cc;
  logic       dp_ca, dp_cc, fd_ca, fd_cc;
  logic [3:0] an_ca, an_cc;

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_CYC(1), .COMMON_ANODE(1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hold(hold),
    .ones(ones), .tenths(tenths), .hundreths(hundreths), .thousandths(thousandths),
    .seg(seg_ca), .dp(dp_ca), .an(an_ca), .frame_done(fd_ca)
  );

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_CYC(1), .COMMON_ANODE(0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hold(hold),
    .ones(ones), .tenths(tenths), .hundreths(hundreths), .thousandths(thousandths),
    .seg(seg_cc), .dp(dp_cc), .an(an_cc), .frame_done(fd_cc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } ev_t;

  ev_t q_ca[$];
  ev_t q_cc[$];
  ev_t exp_ca, exp_cc;
  int  total = 0;
  int  bad = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // One lit cycle of slot s showing digit d (active-high form for the common-cathode copy)
  task automatic push_ev(input int s, input logic [3:0] d, input logic fd);
    ev_t e;
    e.an  = 4'(1 << s);
    e.seg = ref_seg(d);
    e.dp  = (s == 3);
    e.fd  = fd;
    q_cc.push_back(e);
    e.an  = ~e.an;
    e.seg = ~e.seg;
    e.dp  = ~e.dp;
    q_ca.push_back(e);
  endtask

  // A frame is 3 lit cycles per slot (first cycle blanked); frame_done rides the last one
  task automatic push_frame(input logic [15:0] v);
    logic [3:0] d;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       d = v[3:0];
        1:       d = v[7:4];
        2:       d = v[11:8];
        default: d = v[15:12];
      endcase
      for (int p = 1; p < 4; p++) push_ev(s, d, (s == 3) && (p == 3));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (an_ca != 4'hF || fd_ca) begin
      total++;
      if (q_ca.size() == 0) begin
        bad++;
        $display("FAIL ca_unexpected: got an=%h seg=%h dp=%b fd=%b, want no output",
                 an_ca, seg_ca, dp_ca, fd_ca);
      end else begin
        exp_ca = q_ca.pop_front();
        if ({an_ca, seg_ca, dp_ca, fd_ca} !== exp_ca) begin
          bad++;
          $display("FAIL ca_event: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                   an_ca, seg_ca, dp_ca, fd_ca, exp_ca.an, exp_ca.seg, exp_ca.dp, exp_ca.fd);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (an_cc != 4'h0 || fd_cc) begin
      total++;
      if (q_cc.size() == 0) begin
        bad++;
        $display("FAIL cc_unexpected: got an=%h seg=%h dp=%b fd=%b, want no output",
                 an_cc, seg_cc, dp_cc, fd_cc);
      end else begin
        exp_cc = q_cc.pop_front();
        if ({an_cc, seg_cc, dp_cc, fd_cc} !== exp_cc) begin
          bad++;
          $display("FAIL cc_event: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                   an_cc, seg_cc, dp_cc, fd_cc, exp_cc.an, exp_cc.seg, exp_cc.dp, exp_cc.fd);
        end
      end
    end
  end

  // Per frame: value shown, inputs applied mid-frame, hold applied mid-frame
  logic [15:0] disp_tab [8] = '{16'h0000, 16'h1234, 16'h8675, 16'h8675,
                                16'h8675, 16'h8675, 16'h9012, 16'h901C};
  logic [15:0] set_tab  [8] = '{16'h1234, 16'h8675, 16'h9012, 16'h9012,
                                16'h9012, 16'h9012, 16'h901C, 16'h901C};
  logic        hold_tab [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    {ones, tenths, hundreths, thousandths} = 16'h1234;
    enable = 1'b1;
    hold   = 1'b0;
    rst_n  = 1'b0;
    tick(3);
    chk("rst_seg_ca", 32'(seg_ca), 32'h7F);
    chk("rst_dp_ca",  32'(dp_ca),  32'h1);
    chk("rst_an_ca",  32'(an_ca),  32'hF);
    chk("rst_fd_ca",  32'(fd_ca),  32'h0);
    chk("rst_seg_cc", 32'(seg_cc), 32'h00);
    chk("rst_an_cc",  32'(an_cc),  32'h0);
    chk("rst_dp_cc",  32'(dp_cc),  32'h0);
    rst_n = 1'b1;

    // Snapshot, hold and invalid-digit frames
    for (int f = 0; f < 8; f++) begin
      push_frame(disp_tab[f]);
      tick(8);
      {ones, tenths, hundreths, thousandths} = set_tab[f];
      hold = hold_tab[f];
      tick(8);
    end

    // Enable dropped at slot 2, prescaler 1, for 10 cycles
    push_frame(16'h901C);
    tick(9);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_an_ca", 32'(an_ca), 32'hF);
      chk("dis_fd_ca", 32'(fd_ca), 32'h0);
      chk("dis_an_cc", 32'(an_cc), 32'h0);
    end
    enable = 1'b1;
    tick(7);

    push_frame(16'h901C);
    tick(16);

    // Asynchronous reset while slot 0 is lit
    push_ev(0, 4'hC, 1'b0);
    push_ev(0, 4'hC, 1'b0);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg_ca", 32'(seg_ca), 32'h7F);
    chk("arst_dp_ca",  32'(dp_ca),  32'h1);
    chk("arst_an_ca",  32'(an_ca),  32'hF);
    chk("arst_an_cc",  32'(an_cc),  32'h0);
    tick(2);
    rst_n = 1'b1;

    // Snapshot discarded by reset; frame_done lands 16 cycles after release
    push_frame(16'h0000);
    tick(16);
    for (int i = 0; i < 8 && (q_ca.size() != 0 || q_cc.size() != 0); i++) @(negedge clk);
    chk("ca_queue_left", 32'(q_ca.size()), 32'd0);
    chk("cc_queue_left", 32'(q_cc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no completion, want completion before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
